booth_radix4_mul: RTL and testbench

BOOTH_RADIX4_MUL -- requirements
Module: booth_radix4_mul

---
 rtl/booth_radix4_mul.sv | 125 ++++++++++++
 tb/tb_booth_radix4_mul.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, WIDTH/2+1 steps per product.
// Optional zero-operand shortcut enabled by defining BOOTH_ZERO_SKIP_EN.
module booth_radix4_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int E  = WIDTH + 2;
  localparam int H  = E + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [E-1:0]     a_ext;
  logic [E-1:0]     mreg;
  logic [H-1:0]     acc_hi;
  logic             prev;

  logic             accept;
  logic             zero_op;
  logic             last;
  logic [H-1:0]     a_wide;
  logic [H-1:0]     pp;
  logic [H-1:0]     sum;
  logic [H-1:0]     hi_nxt;
  logic [E-1:0]     lo_nxt;
  logic [2*WIDTH-1:0] product;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CW'(1));

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = zero_op ? DONE : RUN;
      RUN:        if (cnt == CW'(1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Booth digit {m1, m0, prev} selects 0, +/-A or +/-2A; the add is followed by an arithmetic shift by 2.
  always_comb begin
    a_wide = {{2{a_ext[E-1]}}, a_ext};
    pp     = '0;
    case ({mreg[1:0], prev})
      3'b001, 3'b010: pp = a_wide;
      3'b011:         pp = a_wide << 1;
      3'b100:         pp = -(a_wide << 1);
      3'b101, 3'b110: pp = -a_wide;
      default:        pp = '0;
    endcase
    sum     = acc_hi + pp;
    hi_nxt  = {{2{sum[H-1]}}, sum[H-1:2]};
    lo_nxt  = {sum[1:0], mreg[E-1:2]};
    product = {hi_nxt[2*WIDTH-E-1:0], lo_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_ext  <= '0;
      mreg   <= '0;
      acc_hi <= '0;
      prev   <= 1'b0;
      ready  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (zero_op) begin
          result <= '0;
          ready  <= 1'b1;
          done   <= 1'b1;
        end else begin
          a_ext  <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
          mreg   <= is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
          acc_hi <= '0;
          prev   <= 1'b0;
          cnt    <= CW'(N);
          ready  <= 1'b0;
        end
      end else if (state == RUN) begin
        acc_hi <= hi_nxt;
        mreg   <= lo_nxt;
        prev   <= mreg[1];
        cnt    <= cnt - CW'(1);
        if (last) begin
          result <= product;
          ready  <= 1'b1;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul (WIDTH=16) against an integer-arithmetic reference.
// Expectations for the zero-operand path follow BOOTH_ZERO_SKIP_EN.
module tb_booth_radix4_mul;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 2 + 1;
  localparam int LAT   = N + 1;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZLAT  = 1;
  localparam logic ZBUSY = 1'b0;
`else
  localparam int ZLAT  = LAT;
  localparam logic ZBUSY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, ready, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  booth_radix4_mul #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint px, py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'({48'd0, x});
      py = longint'({48'd0, y});
    end
    return 32'(px * py);
  endfunction

  // Launch one operation; edge_idx counts the start-sampling edge as 1, -1 on timeout.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        output logic [31:0] res, output int edge_idx, output logic busy_seen);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
    busy_seen = busy;
    edge_idx = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        edge_idx = i;
        break;
      end
      @(posedge clk); #1;
    end
    res = result;
  endtask

  task automatic test_reset();
    int idx;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ready, done} !== 3'b000 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: busy/ready/done=%b result=%h, required 000 / 0", {busy, ready, done}, result);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, ready, done} !== 3'b000 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: busy/ready/done=%b result=%h, required 000 / 0", {busy, ready, done}, result);
    end
    @(negedge clk);
    rst_n = 1'b1; a = 16'd7; b = 16'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start_busy: busy=%b, required 1", busy);
    end
    idx = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin idx = i; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (idx != LAT || result !== 32'd21) begin
      errors++;
      $display("FAIL first_start_result: edge=%0d result=%0d, required edge %0d result 21", idx, result, LAT);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va [3] = '{16'd7, 16'h8000, 16'hFFFF};
    logic [15:0] vb [3] = '{16'hFFFD, 16'h8000, 16'hFFFF};
    logic        vs [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] ve [3] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFE0001};
    logic [31:0] res;
    int          idx;
    logic        bs;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], vs[k], res, idx, bs);
      checks++;
      if (res !== ve[k]) begin
        errors++;
        $display("FAIL vector_result[%0d]: got %h, required %h", k, res, ve[k]);
      end
      checks++;
      if (idx != LAT) begin
        errors++;
        $display("FAIL vector_latency[%0d]: done at edge %0d, required %0d", k, idx, LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] corner [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
    logic [15:0] x, y;
    logic        s;
    logic [31:0] res, exp;
    int          idx;
    logic        bs;
    for (int k = 0; k < 30; k++) begin
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom_range(1, 65535));
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom_range(1, 65535));
      s = 1'($urandom);
      exp = model(x, y, s);
      run_op(x, y, s, res, idx, bs);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL random_result: %h*%h signed=%b got %h, required %h", x, y, s, res, exp);
      end
      checks++;
      if (idx != LAT || bs !== 1'b1 || ready !== 1'b1) begin
        errors++;
        $display("FAIL random_handshake: edge=%0d busy=%b ready=%b, required edge %0d busy 1 ready 1", idx, bs, ready, LAT);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || result !== exp) begin
        errors++;
        $display("FAIL random_hold: done=%b ready=%b result=%h, required 0 / 1 / %h", done, ready, result, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    int idx;
    @(negedge clk);
    a = 16'd3; b = 16'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin idx = i; break; end
      if (i == 4) begin start = 1'b1; a = 16'd9; b = 16'd9; end
      if (i == 5) start = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (idx != LAT || result !== 32'd15) begin
      errors++;
      $display("FAIL ignore_start: edge=%0d result=%0d, required edge %0d result 15", idx, result, LAT);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result !== 32'd15) begin
      errors++;
      $display("FAIL ignore_no_restart: busy=%b result=%0d, required 0 / 15", busy, result);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, i;
    @(negedge clk);
    a = 16'd2; b = 16'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    i = 1; d1 = -1; d2 = -1;
    while (i <= 40 && d1 < 0) begin
      if (done) d1 = i;
      else begin @(posedge clk); #1; i++; end
    end
    checks++;
    if (d1 != LAT || result !== 32'd6) begin
      errors++;
      $display("FAIL b2b_first: edge=%0d result=%0d, required edge %0d result 6", d1, result, LAT);
    end
    a = 16'd4; b = 16'd5;
    @(posedge clk); #1; i++;
    while (i <= 80 && d2 < 0) begin
      if (done) begin d2 = i; start = 1'b0; end
      else begin @(posedge clk); #1; i++; end
    end
    start = 1'b0;
    checks++;
    if (d1 < 0 || d2 < 0 || d2 - d1 != LAT) begin
      errors++;
      $display("FAIL b2b_spacing: first %0d second %0d, required spacing %0d", d1, d2, LAT);
    end
    checks++;
    if (result !== 32'd20) begin
      errors++;
      $display("FAIL b2b_second: result=%0d, required 20", result);
    end
  endtask

  task automatic test_reset_during_run();
    logic seen;
    @(negedge clk);
    a = 16'd6; b = 16'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: busy=%b ready=%b done=%b, required 0 0 0", busy, ready, done);
    end
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL abort_result: result=%h, required 0", result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done_seen=%b busy=%b, required 0 0", seen, busy);
    end
  endtask

  task automatic test_zero();
    logic [31:0] res;
    int          idx;
    logic        bs;
    run_op(16'd0, 16'h1234, 1'b0, res, idx, bs);
    checks++;
    if (res !== 32'd0 || idx != ZLAT) begin
      errors++;
      $display("FAIL zero_a: result=%h edge=%0d, required 0 edge %0d", res, idx, ZLAT);
    end
    checks++;
    if (bs !== ZBUSY || ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_a_flags: busy=%b ready=%b, required %b 1", bs, ready, ZBUSY);
    end
    run_op(16'hABCD, 16'd0, 1'b1, res, idx, bs);
    checks++;
    if (res !== 32'd0 || idx != ZLAT) begin
      errors++;
      $display("FAIL zero_b: result=%h edge=%0d, required 0 edge %0d", res, idx, ZLAT);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_during_run();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
